// File: rtl/fbox_issue_pkg.sv
// Shared types and constants for the FBox issue controller: legal FP major
// opcodes, fflag bit positions, FSM state encoding and the queued request
// record.
package fbox_issue_pkg;

   // FP major opcodes accepted for issue to the core
   localparam logic [6:0] OP_FP     = 7'h53;
   localparam logic [6:0] OP_FMADD  = 7'h43;
   localparam logic [6:0] OP_FMSUB  = 7'h47;
   localparam logic [6:0] OP_FNMSUB = 7'h4B;
   localparam logic [6:0] OP_FNMADD = 7'h4F;

   // Bit positions inside the 5-bit fflags word (NV is the MSB)
   typedef enum int {
      FLAG_NX = 0,
      FLAG_UF = 1,
      FLAG_OF = 2,
      FLAG_DZ = 3,
      FLAG_NV = 4
   } fflag_bit_e;

   // Result flags reported for requests the core never sees
   localparam logic [4:0] FLAG_NV_ONLY = 5'(1 << FLAG_NV);

   // Widest tag the queued record can carry; narrower tags are zero-extended
   localparam int TAG_W_MAX = 8;

   typedef enum logic [1:0] {
      RST_REQ = 2'd0,
      RST_RSP = 2'd1,
      IDLE    = 2'd2,
      WAIT    = 2'd3
   } state_e;

   typedef struct packed {
      logic [6:0]           opcode;
      logic [6:0]           f7;
      logic [2:0]           rm;
      logic [4:0]           rs2;
      logic [63:0]          v1;
      logic [63:0]          v2;
      logic [63:0]          v3;
      logic [TAG_W_MAX-1:0] tag;
   } req_t;

   function automatic logic is_legal_op(input logic [6:0] op);
      return (op == OP_FP) || (op == OP_FMADD) || (op == OP_FMSUB) ||
             (op == OP_FNMSUB) || (op == OP_FNMADD);
   endfunction

endpackage

// File: rtl/fbox_issue_ctrl_if.sv
// Bundle of the request, result and core-facing signals of the FBox issue
// controller. The controller uses the slave view; the pipeline/core
// environment uses the master view.
interface fbox_issue_ctrl_if #(
   parameter int TAG_W = 4
);
   // request from the pipeline
   logic             in_valid;
   logic             in_ready;
   logic [6:0]       in_opcode;
   logic [6:0]       in_f7;
   logic [2:0]       in_rm;
   logic [4:0]       in_rs2;
   logic [63:0]      in_v1;
   logic [63:0]      in_v2;
   logic [63:0]      in_v3;
   logic [TAG_W-1:0] in_tag;
   // result towards writeback
   logic             out_valid;
   logic             out_ready;
   logic [63:0]      out_value;
   logic [4:0]       out_fflags;
   logic [TAG_W-1:0] out_tag;
   logic             out_timeout;
   logic             busy;
   // core server-reset handshake
   logic             core_en_rst_req;
   logic             core_rdy_rst_req;
   logic             core_en_rst_rsp;
   logic             core_rdy_rst_rsp;
   // core request / result
   logic             core_en_req;
   logic [6:0]       core_opcode;
   logic [6:0]       core_f7;
   logic [2:0]       core_rm;
   logic [4:0]       core_rs2;
   logic [63:0]      core_v1;
   logic [63:0]      core_v2;
   logic [63:0]      core_v3;
   logic             core_valid;
   logic [63:0]      core_word_fst;
   logic [4:0]       core_word_snd;

   modport slave (
      input  in_valid, in_opcode, in_f7, in_rm, in_rs2, in_v1, in_v2, in_v3, in_tag,
      output in_ready,
      output out_valid, out_value, out_fflags, out_tag, out_timeout, busy,
      input  out_ready,
      output core_en_rst_req, core_en_rst_rsp,
      input  core_rdy_rst_req, core_rdy_rst_rsp,
      output core_en_req, core_opcode, core_f7, core_rm, core_rs2,
      output core_v1, core_v2, core_v3,
      input  core_valid, core_word_fst, core_word_snd
   );

   modport master (
      output in_valid, in_opcode, in_f7, in_rm, in_rs2, in_v1, in_v2, in_v3, in_tag,
      input  in_ready,
      input  out_valid, out_value, out_fflags, out_tag, out_timeout, busy,
      output out_ready,
      input  core_en_rst_req, core_en_rst_rsp,
      output core_rdy_rst_req, core_rdy_rst_rsp,
      input  core_en_req, core_opcode, core_f7, core_rm, core_rs2,
      input  core_v1, core_v2, core_v3,
      output core_valid, core_word_fst, core_word_snd
   );

endinterface

// File: rtl/fbox_req_fifo.sv
// DEPTH-entry synchronous FIFO of FP requests. The head entry is visible
// combinationally so the issue logic can decode its opcode in the same
// cycle. Callers never push when full nor pop when empty.
module fbox_req_fifo
   import fbox_issue_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                     CLK,
   input  logic                     RST_N,
   input  logic                     push,
   input  req_t                     push_data,
   input  logic                     pop,
   output req_t                     head,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int PTR_W = $clog2(DEPTH);

   req_t             mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr_reg;
   logic [PTR_W-1:0] rd_ptr_reg;
   logic [PTR_W:0]   count_reg;

   // storage write; contents only matter once counted as valid
   always_ff @(posedge CLK) begin
      if (push) begin
         mem[wr_ptr_reg] <= push_data;
      end
   end

   // pointers wrap naturally because DEPTH is a power of two
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
         case ({push, pop})
            2'b10:   count_reg <= count_reg + 1'b1;
            2'b01:   count_reg <= count_reg - 1'b1;
            default: count_reg <= count_reg;
         endcase
      end
   end

   assign head  = mem[rd_ptr_reg];
   assign empty = (count_reg == '0);
   assign count = count_reg;

endmodule

// File: rtl/fbox_issue_ctrl.sv
// FBox issue controller: queues tagged FP requests, runs the core's
// server-reset handshake, issues one request at a time and holds each
// result in a ready/valid register for writeback.
// Optional feature: define FBOX_WDOG_EN to add a WAIT-state watchdog that
// reports a timeout result and re-runs the core reset handshake.
module fbox_issue_ctrl
   import fbox_issue_pkg::*;
#(
   parameter int DEPTH          = 4,
   parameter int TAG_W          = 4,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic               CLK,
   input  logic               RST_N,
   fbox_issue_ctrl_if.slave   bus
);
   localparam int CNT_W = $clog2(DEPTH) + 1;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

   // parameter sanity checks at elaboration
   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("fbox_issue_ctrl: DEPTH must be a power of two >= 2");
   end
   if (TAG_W < 1 || TAG_W > TAG_W_MAX) begin : g_bad_tag
      $error("fbox_issue_ctrl: TAG_W out of range");
   end
   if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
      $error("fbox_issue_ctrl: TIMEOUT_CYCLES must be >= 2");
   end

   state_e           state_reg, state_next;
   req_t             push_data, head;
   logic             fifo_empty;
   logic [CNT_W-1:0] fifo_count;
   logic             push, pop, in_ready_w;
   logic             issue, load_core, load_illegal;
   logic             en_rst_req, en_rst_rsp;
   logic             unused_tag_hi;

   logic             core_en_req_reg;
   logic [6:0]       core_opcode_reg, core_f7_reg;
   logic [2:0]       core_rm_reg;
   logic [4:0]       core_rs2_reg;
   logic [63:0]      core_v1_reg, core_v2_reg, core_v3_reg;
   logic [TAG_W-1:0] tag_reg;

   logic             out_valid_reg;
   logic [63:0]      out_value_reg;
   logic [4:0]       out_fflags_reg;
   logic [TAG_W-1:0] out_tag_reg;

`ifdef FBOX_WDOG_EN
   localparam int WDOG_W = $clog2(TIMEOUT_CYCLES) + 1;
   localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT_CYCLES - 1);
   logic [WDOG_W-1:0] wdog_cnt_reg;
   logic              load_timeout;
   logic              out_timeout_reg;
`endif

   assign push_data = '{opcode: bus.in_opcode, f7: bus.in_f7, rm: bus.in_rm,
                        rs2: bus.in_rs2, v1: bus.in_v1, v2: bus.in_v2,
                        v3: bus.in_v3, tag: TAG_W_MAX'(bus.in_tag)};

   // only the low TAG_W bits of the stored tag carry information
   assign unused_tag_hi = ^head.tag;

   // requests are accepted only once the core reset handshake has completed
   assign in_ready_w = (fifo_count < DEPTH_C) && (state_reg == IDLE || state_reg == WAIT);
   assign push       = bus.in_valid && in_ready_w;

   fbox_req_fifo #(.DEPTH(DEPTH)) u_fifo (
      .CLK       (CLK),
      .RST_N     (RST_N),
      .push      (push),
      .push_data (push_data),
      .pop       (pop),
      .head      (head),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   // FSM state register
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) state_reg <= RST_REQ;
      else        state_reg <= state_next;
   end

   // next-state decode and single-cycle control strobes; the handshake
   // enables are qualified with RST_N so they stay low while reset is held
   always_comb begin
      state_next   = state_reg;
      pop          = 1'b0;
      issue        = 1'b0;
      load_core    = 1'b0;
      load_illegal = 1'b0;
      en_rst_req   = 1'b0;
      en_rst_rsp   = 1'b0;
`ifdef FBOX_WDOG_EN
      load_timeout = 1'b0;
`endif
      case (state_reg)
         RST_REQ: begin
            if (RST_N && bus.core_rdy_rst_req) begin
               en_rst_req = 1'b1;
               state_next = RST_RSP;
            end
         end
         RST_RSP: begin
            if (RST_N && bus.core_rdy_rst_rsp) begin
               en_rst_rsp = 1'b1;
               state_next = IDLE;
            end
         end
         IDLE: begin
            if (!fifo_empty && (!out_valid_reg || bus.out_ready)) begin
               pop = 1'b1;
               if (is_legal_op(head.opcode)) begin
                  issue      = 1'b1;
                  state_next = WAIT;
               end else begin
                  load_illegal = 1'b1;
               end
            end
         end
         WAIT: begin
            if (bus.core_valid) begin
               load_core  = 1'b1;
               state_next = IDLE;
            end
`ifdef FBOX_WDOG_EN
            else if (wdog_cnt_reg == WDOG_LAST) begin
               load_timeout = 1'b1;
               state_next   = RST_REQ;
            end
`endif
         end
         default: state_next = RST_REQ;
      endcase
   end

   // issue register: one-cycle EN_req pulse, fields held for the whole WAIT
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         core_en_req_reg <= 1'b0;
         core_opcode_reg <= '0;
         core_f7_reg     <= '0;
         core_rm_reg     <= '0;
         core_rs2_reg    <= '0;
         core_v1_reg     <= '0;
         core_v2_reg     <= '0;
         core_v3_reg     <= '0;
         tag_reg         <= '0;
      end else begin
         core_en_req_reg <= issue;
         if (issue) begin
            core_opcode_reg <= head.opcode;
            core_f7_reg     <= head.f7;
            core_rm_reg     <= head.rm;
            core_rs2_reg    <= head.rs2;
            core_v1_reg     <= head.v1;
            core_v2_reg     <= head.v2;
            core_v3_reg     <= head.v3;
            tag_reg         <= head.tag[TAG_W-1:0];
         end
      end
   end

   // result register: a new load wins over a simultaneous drain
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         out_valid_reg  <= 1'b0;
         out_value_reg  <= '0;
         out_fflags_reg <= '0;
         out_tag_reg    <= '0;
`ifdef FBOX_WDOG_EN
         out_timeout_reg <= 1'b0;
`endif
      end else if (load_core) begin
         out_valid_reg  <= 1'b1;
         out_value_reg  <= bus.core_word_fst;
         out_fflags_reg <= bus.core_word_snd;
         out_tag_reg    <= tag_reg;
`ifdef FBOX_WDOG_EN
         out_timeout_reg <= 1'b0;
`endif
      end else if (load_illegal) begin
         out_valid_reg  <= 1'b1;
         out_value_reg  <= '0;
         out_fflags_reg <= FLAG_NV_ONLY;
         out_tag_reg    <= head.tag[TAG_W-1:0];
`ifdef FBOX_WDOG_EN
         out_timeout_reg <= 1'b0;
      end else if (load_timeout) begin
         out_valid_reg   <= 1'b1;
         out_value_reg   <= '0;
         out_fflags_reg  <= FLAG_NV_ONLY;
         out_tag_reg     <= tag_reg;
         out_timeout_reg <= 1'b1;
`endif
      end else if (out_valid_reg && bus.out_ready) begin
         out_valid_reg <= 1'b0;
      end
   end

`ifdef FBOX_WDOG_EN
   // watchdog: zero on the first WAIT cycle, counts every WAIT cycle after
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N)                 wdog_cnt_reg <= '0;
      else if (issue)             wdog_cnt_reg <= '0;
      else if (state_reg == WAIT) wdog_cnt_reg <= wdog_cnt_reg + 1'b1;
   end
   assign bus.out_timeout = out_timeout_reg;
`else
   assign bus.out_timeout = 1'b0;
`endif

   assign bus.in_ready        = in_ready_w;
   assign bus.out_valid       = out_valid_reg;
   assign bus.out_value       = out_value_reg;
   assign bus.out_fflags      = out_fflags_reg;
   assign bus.out_tag         = out_tag_reg;
   assign bus.busy            = !fifo_empty || (state_reg != IDLE) || out_valid_reg;
   assign bus.core_en_rst_req = en_rst_req;
   assign bus.core_en_rst_rsp = en_rst_rsp;
   assign bus.core_en_req     = core_en_req_reg;
   assign bus.core_opcode     = core_opcode_reg;
   assign bus.core_f7         = core_f7_reg;
   assign bus.core_rm         = core_rm_reg;
   assign bus.core_rs2        = core_rs2_reg;
   assign bus.core_v1         = core_v1_reg;
   assign bus.core_v2         = core_v2_reg;
   assign bus.core_v3         = core_v3_reg;

endmodule
